// File: rtl/ma_request_sequencer.sv
// rtl/ma_request_sequencer.sv - request FIFO and single-command sequencer in front of the MA memory
//
// Purpose:
//   Queues compress/decompress requests and issues them to MA one at a time
//   as single-cycle commands. Each command ends in one result on the result
//   port. The result comes from MA's response, or is an error if MA times out.
//   A sticky mem_full flag is set when MA rejects a compress. While it is set,
//   compress requests are failed locally and are not sent to MA.
//
// Optional build macro:
//   MA_SEQ_STATS_EN - adds the stat_comp_ok / stat_decomp_ok / stat_err
//                     16-bit saturating result counters.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; req_op 00 nop, 01 compress,
//                        10 decompress, 11 reserved; req_data, req_index payload
//   ma_command           one-cycle command pulse to MA (req_op encoding)
//   ma_data_in           data word driven to MA, held stable for the whole transaction
//   ma_compressed_in     compressed index driven to MA, held stable for the whole transaction
//   ma_compressed_out    index returned by MA
//   ma_decompressed_out  data word returned by MA
//   ma_response          MA response: 00 none, 01 compress ok, 10 decompress ok, 11 error
//   res_valid/res_ready  result handshake; res_status, res_timeout, res_index,
//                        res_data are held while res_valid is high
//   mem_full             sticky dictionary-full flag, cleared only by reset

module ma_request_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [79:0] req_data,
    input  logic [7:0]  req_index,
    output logic [1:0]  ma_command,
    output logic [79:0] ma_data_in,
    output logic [7:0]  ma_compressed_in,
    input  logic [7:0]  ma_compressed_out,
    input  logic [79:0] ma_decompressed_out,
    input  logic [1:0]  ma_response,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_status,
    output logic        res_timeout,
    output logic [7:0]  res_index,
    output logic [79:0] res_data,
`ifdef MA_SEQ_STATS_EN
    output logic [15:0] stat_comp_ok,
    output logic [15:0] stat_decomp_ok,
    output logic [15:0] stat_err,
`endif
    output logic        mem_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);

    localparam logic [1:0] OP_COMP   = 2'b01;
    localparam logic [1:0] OP_DECOMP = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;
    localparam logic [1:0] RSP_ERR   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t state, state_next;

    // Request FIFO
    logic [1:0]  fifo_op    [DEPTH];
    logic [79:0] fifo_data  [DEPTH];
    logic [7:0]  fifo_index [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_next;

    logic [1:0]    op_q;
    logic [TW-1:0] timer;

    logic push, pop, reject;
    logic issue_load, reject_load, capture_load, timeout_load, handshake;
    logic [1:0]  head_op;
    logic [79:0] head_data;
    logic [7:0]  head_index;

    // A no-op is accepted from the requester but never stored in the FIFO.
    assign push       = req_valid & req_ready & (req_op != 2'b00);
    assign pop        = (state == S_IDLE) && (count != '0);
    assign head_op    = fifo_op[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign head_index = fifo_index[rd_ptr];
    // Requests that cannot succeed finish locally without being sent to MA.
    assign reject     = (head_op == OP_RSVD) || ((head_op == OP_COMP) && mem_full);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            req_ready <= (count_next < DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]    <= req_op;
            fifo_data[wr_ptr]  <= req_data;
            fifo_index[wr_ptr] <= req_index;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pop) state_next = reject ? S_DONE : S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (capture_load || timeout_load) state_next = S_DONE;
            S_DONE:  if (handshake) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output/datapath load decode. A response in the timeout cycle takes priority.
    always_comb begin
        issue_load   = pop && !reject;
        reject_load  = pop && reject;
        capture_load = (state == S_WAIT) && (ma_response != 2'b00);
        timeout_load = (state == S_WAIT) && (ma_response == 2'b00) && (timer == TMAX);
        handshake    = (state == S_DONE) && res_valid && res_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ma_command       <= 2'b00;
            ma_data_in       <= '0;
            ma_compressed_in <= '0;
            op_q             <= 2'b00;
            timer            <= '0;
            res_valid        <= 1'b0;
            res_status       <= 2'b00;
            res_timeout      <= 1'b0;
            res_index        <= '0;
            res_data         <= '0;
            mem_full         <= 1'b0;
        end else begin
            // The command register is high only during ISSUE.
            ma_command <= issue_load ? head_op : 2'b00;

            if (pop)
                op_q <= head_op;

            if (issue_load) begin
                ma_data_in       <= head_data;
                ma_compressed_in <= head_index;
            end

            if (state == S_ISSUE)
                timer <= '0;
            else if ((state == S_WAIT) && !capture_load && !timeout_load)
                timer <= timer + 1'b1;

            if (reject_load) begin
                res_valid   <= 1'b1;
                res_status  <= RSP_ERR;
                res_timeout <= 1'b0;
                res_index   <= '0;
                res_data    <= '0;
            end else if (capture_load) begin
                res_valid   <= 1'b1;
                res_status  <= ma_response;
                res_timeout <= 1'b0;
                res_index   <= ma_compressed_out;
                res_data    <= ma_decompressed_out;
                if ((op_q == OP_COMP) && (ma_response == RSP_ERR))
                    mem_full <= 1'b1;
            end else if (timeout_load) begin
                res_valid   <= 1'b1;
                res_status  <= RSP_ERR;
                res_timeout <= 1'b1;
                res_index   <= '0;
                res_data    <= '0;
            end else if (handshake) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MA_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_comp_ok   <= '0;
            stat_decomp_ok <= '0;
            stat_err       <= '0;
        end else if (handshake) begin
            if ((res_status == OP_COMP) && (stat_comp_ok != 16'hFFFF))
                stat_comp_ok <= stat_comp_ok + 16'd1;
            if ((res_status == OP_DECOMP) && (stat_decomp_ok != 16'hFFFF))
                stat_decomp_ok <= stat_decomp_ok + 16'd1;
            if ((res_status == RSP_ERR) && (stat_err != 16'hFFFF))
                stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ma_request_sequencer.md
Name: ma_request_sequencer

Overview:
- Front-end stage directly upstream of the MA compression/decompression memory.
- Buffers compress and decompress requests in a FIFO and issues them to MA one at a time as single-cycle commands.
- Waits for MA's response, or times out, then returns the result through a valid/ready result port.
- Tracks a sticky "dictionary full" condition so that compress requests which cannot succeed are not issued.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, ≥2)
TIMEOUT, 16, max cycles in WAIT before forcing an error result (≥1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept
req_op  in  2  00 no-op, 01 compress, 10 decompress, 11 reserved
req_data  in  80  data word for compress
req_index  in  8  compressed index for decompress
ma_command  out  2  command to MA (same encoding as req_op)
ma_data_in  out  80  to MA data_in
ma_compressed_in  out  8  to MA compressed_in
ma_compressed_out  in  8  from MA
ma_decompressed_out  in  80  from MA
ma_response  in  2  00 none, 01 compress ok, 10 decompress ok, 11 error
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_status  out  2  captured response; 11 also used for timeout, reserved op, or full-reject
res_timeout  out  1  1 = error caused by timeout
res_index  out  8  compressed index (compress ok)
res_data  out  80  decompressed word (decompress ok)
mem_full  out  1  sticky dictionary-full flag

Behaviour:
- All outputs are registered. One clock domain. Reset is synchronous and active-high.
- Reset:
  - Empties the FIFO, discards any in-flight request, sets state to IDLE.
  - Clears mem_full and all res_* signals.
  - ma_command=00; ma_data_in and ma_compressed_in are 0.
  - Reset asserted in WAIT drops the pending request; no result is produced for it.
- FIFO:
  - Entry is {op, data, index}. req_ready = (count < DEPTH).
  - Push on req_valid & req_ready. op=00 is accepted and silently dropped (not stored).
  - Push and pop in the same cycle are both honoured. When full, req_ready=0 and no bypass is allowed.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If FIFO is non-empty, pop the head into the working registers.
  - op=11 → DONE with status 11, no MA command issued.
  - op=01 with mem_full=1 → DONE with status 11, not issued.
  - Otherwise → ISSUE, and load ma_data_in / ma_compressed_in from the entry.
- ISSUE:
  - ma_command = op for exactly one cycle; timer cleared.
  - → WAIT.
- WAIT:
  - ma_command=00. ma_data_in and ma_compressed_in are held stable.
  - On ma_response≠00: capture status, index and data → DONE.
  - Otherwise the timer increments. When timer==TIMEOUT-1 → DONE with status 11 and res_timeout=1.
  - If a response and the timeout occur in the same cycle, the response wins.
- DONE:
  - res_valid=1; res_* held stable until res_ready.
  - On res_valid & res_ready → IDLE and res_valid=0.
  - The next pop happens no earlier than the cycle after the handshake.
- mem_full is set when a compress request receives ma_response=11. It is cleared only by reset. Decompress requests are unaffected by mem_full.
- Latency:
  - Request accepted at edge N into an empty FIFO → ma_command visible after edge N+1.
  - MA responding one cycle later → res_valid high after edge N+3.
- ma_response values seen outside WAIT are ignored.

Optional Feature:
- Macro: MA_SEQ_STATS_EN.
- When defined, adds three 16-bit saturating output counters:
  - stat_comp_ok: compress ok
  - stat_decomp_ok: decompress ok
  - stat_err: every status-11 result, including timeout and rejects
- Each counter increments on the res_valid & res_ready handshake. Counters clear on reset and saturate at 16'hFFFF.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released → req_ready=1, res_valid=0, ma_command=00, mem_full=0.
- Compress data=80'h1, MA model returns 01 with index 8'h00 one cycle after the command, res_ready=1 → one-cycle ma_command=01 pulse; res_status=01, res_index=8'h00, res_valid high 3 edges after accept.
- Five compress requests pushed back-to-back with res_ready=0, DEPTH=4 → req_ready drops after the 4th push plus the pop; no request lost; results delivered in order once res_ready=1.
- Decompress index 8'h05, MA never responds, TIMEOUT=16 → res_status=11, res_timeout=1 exactly 16 cycles after entering WAIT.
- Compress returns 11 (dictionary full) → mem_full=1; next compress completes with status 11 and no ma_command pulse; a following decompress is still issued and returns 10 with res_data from MA.
- Reset asserted during WAIT with a response arriving the same cycle → no result produced, FIFO empty, state IDLE, mem_full=0.
